// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP frame transmitter: FSM states, default 640x480 timing
// and a small helper used to size the line counter.
package dvp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    BACK   = 3'd2,
    ACTIVE = 3'd3,
    FRONT  = 3'd4
  } state_e;

  localparam int DEF_H_ACT   = 640;
  localparam int DEF_H_BLANK = 144;
  localparam int DEF_V_SYNC  = 3;
  localparam int DEF_V_BACK  = 17;
  localparam int DEF_V_ACT   = 480;
  localparam int DEF_V_FRONT = 10;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// Horizontal/line counter pair for the DVP transmitter. Counters run in every non-IDLE
// state; the line counter restarts whenever the FSM moves to its next state.
module dvp_timing_gen
  import dvp_pkg::*;
#(
  parameter int H_ACT   = DEF_H_ACT,
  parameter int H_BLANK = DEF_H_BLANK,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BACK  = DEF_V_BACK,
  parameter int V_ACT   = DEF_V_ACT,
  parameter int V_FRONT = DEF_V_FRONT
) (
  input  logic   clk,
  input  logic   rst_n,
  input  state_e state,
  output logic   line_end,
  output logic   seg_last,
  output logic   frame_end,
  output logic   active_win,
  output logic   h_odd
);

  localparam int LINE = 2 * H_ACT + H_BLANK;
  localparam int HW   = $clog2(LINE);
  localparam int VMAX = max4(V_SYNC, V_BACK, V_ACT, V_FRONT);
  localparam int VW   = (VMAX > 1) ? $clog2(VMAX) : 1;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [VW-1:0] last_line;

  always_comb begin
    last_line = '0;
    case (state)
      SYNC:    last_line = VW'(V_SYNC - 1);
      BACK:    last_line = VW'(V_BACK - 1);
      ACTIVE:  last_line = VW'(V_ACT - 1);
      FRONT:   last_line = VW'(V_FRONT - 1);
      default: last_line = '0;
    endcase
  end

  assign line_end   = (h_cnt_q == HW'(LINE - 1));
  assign seg_last   = (v_cnt_q == last_line);
  assign frame_end  = line_end && seg_last && (state == FRONT);
  assign active_win = (state == ACTIVE) && ({1'b0, h_cnt_q} < (HW + 1)'(2 * H_ACT));
  assign h_odd      = h_cnt_q[0];

  // The line counter only advances below the last line of the current state, so it never overflows.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (state == IDLE) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (line_end) begin
      h_cnt_d = '0;
      v_cnt_d = seg_last ? '0 : v_cnt_q + 1'b1;
    end else begin
      h_cnt_d = h_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

endmodule

// File: rtl/dvp_frame_tx.sv
// DVP frame transmitter: frame FSM, RGB565-to-byte multiplexer and sticky underflow flag.
// Pixel bytes leave high byte first, one clock after the pixel is accepted.
module dvp_frame_tx
  import dvp_pkg::*;
#(
  parameter int H_ACT   = DEF_H_ACT,
  parameter int H_BLANK = DEF_H_BLANK,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BACK  = DEF_V_BACK,
  parameter int V_ACT   = DEF_V_ACT,
  parameter int V_FRONT = DEF_V_FRONT
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEN,
  input  logic [15:0] iPIX_DATA,
  input  logic        iPIX_VALID,
  output logic        oPIX_READY,
  output logic        oVSYNC,
  output logic        oHREF,
  output logic [7:0]  oDATA,
  output logic        oSOF,
  output logic        oUNDERFLOW
);

  state_e     state_q, state_d;
  logic       line_end, seg_last, frame_end, active_win, h_odd;
  logic       pix_ready;
  logic       vsync_q, vsync_d, sof_q, sof_d, href_q, href_d, und_q, und_d;
  logic [7:0] data_q, data_d, lo_q, lo_d;

  dvp_timing_gen #(
    .H_ACT(H_ACT), .H_BLANK(H_BLANK), .V_SYNC(V_SYNC),
    .V_BACK(V_BACK), .V_ACT(V_ACT), .V_FRONT(V_FRONT)
  ) u_timing (
    .clk        (iCLK),
    .rst_n      (iRST),
    .state      (state_q),
    .line_end   (line_end),
    .seg_last   (seg_last),
    .frame_end  (frame_end),
    .active_win (active_win),
    .h_odd      (h_odd)
  );

  // Handshake: a pixel transfers on any clock where oPIX_READY is high; a low
  // iPIX_VALID there is not a stall -- timing continues and a zero pixel is sent.
  assign pix_ready = active_win && !h_odd;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iEN) state_d = SYNC;
      SYNC:    if (line_end && seg_last) state_d = BACK;
      BACK:    if (line_end && seg_last) state_d = ACTIVE;
      ACTIVE:  if (line_end && seg_last) state_d = FRONT;
      FRONT:   if (frame_end) state_d = iEN ? SYNC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vsync_d = (state_d == SYNC);
    sof_d   = (state_d == SYNC) && (state_q != SYNC);
    href_d  = active_win;
    lo_d    = lo_q;
    data_d  = 8'h00;
    und_d   = und_q;
    if (pix_ready) begin
      data_d = iPIX_VALID ? iPIX_DATA[15:8] : 8'h00;
      lo_d   = iPIX_VALID ? iPIX_DATA[7:0]  : 8'h00;
      und_d  = und_q | !iPIX_VALID;
    end else if (active_win) begin
      data_d = lo_q;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= IDLE;
      vsync_q <= 1'b0;
      sof_q   <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      lo_q    <= 8'h00;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync_d;
      sof_q   <= sof_d;
      href_q  <= href_d;
      data_q  <= data_d;
      lo_q    <= lo_d;
      und_q   <= und_d;
    end
  end

  assign oPIX_READY = pix_ready;
  assign oVSYNC     = vsync_q;
  assign oSOF       = sof_q;
  assign oHREF      = href_q;
  assign oDATA      = data_q;
  assign oUNDERFLOW = und_q;

endmodule

// File: tb/tb_dvp_frame_tx.sv
// Directed bench for dvp_frame_tx on a 4x2 frame (12-clock lines, 60-clock frames).
module tb_dvp_frame_tx;
  import dvp_pkg::*;

  typedef struct packed {
    logic [15:0] data;
    logic        valid;
  } pix_t;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iEN = 1'b0;
  logic [15:0] iPIX_DATA = 16'h0000;
  logic        iPIX_VALID = 1'b0;
  logic        oPIX_READY, oVSYNC, oHREF, oSOF, oUNDERFLOW;
  logic [7:0]  oDATA;

  int n_tests = 0;
  int n_fail  = 0;

  pix_t       pix_q[$];
  logic [7:0] exp_q[$];

  int f, sof_cnt, vs_cnt, href_cnt, rdy_cnt, first_href, last_href, first_rdy;

  dvp_frame_tx #(
    .H_ACT(4), .H_BLANK(4), .V_SYNC(1), .V_BACK(1), .V_ACT(2), .V_FRONT(1)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iEN        (iEN),
    .iPIX_DATA  (iPIX_DATA),
    .iPIX_VALID (iPIX_VALID),
    .oPIX_READY (oPIX_READY),
    .oVSYNC     (oVSYNC),
    .oHREF      (oHREF),
    .oDATA      (oDATA),
    .oSOF       (oSOF),
    .oUNDERFLOW (oUNDERFLOW)
  );

  // clock / watchdog
  always #5 iCLK = ~iCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic push_pix(input logic [15:0] d, input logic v);
    pix_t p;
    p.data  = d;
    p.valid = v;
    pix_q.push_back(p);
  endtask

  task automatic load_f1();
    push_pix(16'hA1B2, 1'b1); push_pix(16'hC3D4, 1'b1);
    push_pix(16'hE5F6, 1'b1); push_pix(16'h0718, 1'b1);
    push_pix(16'h1122, 1'b1); push_pix(16'h3344, 1'b1);
    push_pix(16'h5566, 1'b1); push_pix(16'h7788, 1'b1);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3); exp_q.push_back(8'hD4);
    exp_q.push_back(8'hE5); exp_q.push_back(8'hF6); exp_q.push_back(8'h07); exp_q.push_back(8'h18);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    exp_q.push_back(8'h55); exp_q.push_back(8'h66); exp_q.push_back(8'h77); exp_q.push_back(8'h88);
  endtask

  task automatic load_f3();
    push_pix(16'h9ABC, 1'b1); push_pix(16'hDEAD, 1'b0);
    push_pix(16'h1357, 1'b1); push_pix(16'h2468, 1'b1);
    push_pix(16'h0F1E, 1'b1); push_pix(16'h2D3C, 1'b1);
    push_pix(16'h4B5A, 1'b1); push_pix(16'h6978, 1'b1);
    exp_q.push_back(8'h9A); exp_q.push_back(8'hBC); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h13); exp_q.push_back(8'h57); exp_q.push_back(8'h24); exp_q.push_back(8'h68);
    exp_q.push_back(8'h0F); exp_q.push_back(8'h1E); exp_q.push_back(8'h2D); exp_q.push_back(8'h3C);
    exp_q.push_back(8'h4B); exp_q.push_back(8'h5A); exp_q.push_back(8'h69); exp_q.push_back(8'h78);
  endtask

  // One clock: sample outputs #1 after the edge, score bytes, then drive the next pixel.
  task automatic step();
    pix_t p;
    @(posedge iCLK);
    #1;
    f++;
    if (oHREF) begin
      if (exp_q.size() == 0) check("href_extra", oHREF, 1'b0);
      else check("byte", oDATA, exp_q.pop_front());
      href_cnt++;
      if (first_href < 0) first_href = f;
      last_href = f;
    end else begin
      check("blank_zero", oDATA, 8'h00);
    end
    if (oVSYNC) vs_cnt++;
    if (oSOF) sof_cnt++;
    if (oPIX_READY) begin
      rdy_cnt++;
      if (first_rdy < 0) first_rdy = f;
    end
    if (oPIX_READY && pix_q.size() > 0) begin
      p = pix_q.pop_front();
      iPIX_DATA  = p.data;
      iPIX_VALID = p.valid;
    end else begin
      iPIX_DATA  = 16'($urandom);
      iPIX_VALID = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic clear_frame_stats();
    f = -1; sof_cnt = 0; vs_cnt = 0; href_cnt = 0; rdy_cnt = 0;
    first_href = -1; last_href = -1; first_rdy = -1;
  endtask

  // Runs one 60-clock frame whose first clock must carry oSOF; drops iEN at frame clock drop_at.
  task automatic run_frame(input int drop_at);
    clear_frame_stats();
    for (int i = 0; i < 60; i++) begin
      step();
      if (i == 0) begin
        check("sof_first", oSOF, 1'b1);
        check("vsync_first", oVSYNC, 1'b1);
      end
      if (i == drop_at) iEN = 1'b0;
    end
    check("sof_count", sof_cnt, 1);
    check("vsync_clocks", vs_cnt, 12);
    check("href_clocks", href_cnt, 16);
    check("ready_clocks", rdy_cnt, 8);
    check("first_ready", first_rdy, 24);
    check("first_href", first_href, 25);
    check("last_href", last_href, 44);
    check("bytes_left", exp_q.size(), 0);
    check("pix_left", pix_q.size(), 0);
  endtask

  initial begin
    clear_frame_stats();
    #3;
    check("rst_vsync", oVSYNC, 1'b0);
    check("rst_href", oHREF, 1'b0);
    check("rst_data", oDATA, 8'h00);
    check("rst_sof", oSOF, 1'b0);
    check("rst_und", oUNDERFLOW, 1'b0);
    check("rst_ready", oPIX_READY, 1'b0);
    @(negedge iCLK);
    @(negedge iCLK);
    iRST = 1'b1;

    // iEN low: nothing starts
    for (int i = 0; i < 100; i++) begin
      step();
      check("idle_quiet", {oVSYNC, oHREF, oPIX_READY, oSOF}, 4'b0000);
    end

    // back-to-back frames with iEN held
    iEN = 1'b1;
    load_f1();
    run_frame(-1);
    check("und_clean_f1", oUNDERFLOW, 1'b0);
    load_f1();
    run_frame(-1);
    check("und_clean_f2", oUNDERFLOW, 1'b0);

    // missing pixel on second ready clock of line 0
    load_f3();
    run_frame(-1);
    check("und_set", oUNDERFLOW, 1'b1);

    // iEN dropped in ACTIVE: frame completes, then IDLE
    load_f1();
    run_frame(30);
    check("und_sticky", oUNDERFLOW, 1'b1);
    clear_frame_stats();
    for (int i = 0; i < 30; i++) begin
      step();
      check("post_drop_quiet", {oVSYNC, oHREF, oPIX_READY, oSOF}, 4'b0000);
    end
    check("post_drop_state", 32'(dut.state_q), 32'(IDLE));

    // reset at h=5 of the first active line
    iEN = 1'b1;
    load_f1();
    clear_frame_stats();
    for (int i = 0; i < 30; i++) step();
    check("pre_rst_href", oHREF, 1'b1);
    iRST = 1'b0;
    #1;
    check("abort_vsync", oVSYNC, 1'b0);
    check("abort_href", oHREF, 1'b0);
    check("abort_data", oDATA, 8'h00);
    check("abort_sof", oSOF, 1'b0);
    check("abort_und", oUNDERFLOW, 1'b0);
    check("abort_ready", oPIX_READY, 1'b0);
    exp_q.delete();
    pix_q.delete();
    @(posedge iCLK);
    #1;
    check("rst_hold_sof", oSOF, 1'b0);
    @(negedge iCLK);
    iRST = 1'b1;
    load_f1();
    run_frame(-1);
    check("und_after_rst", oUNDERFLOW, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
